// File: rtl/plane_war_pkg.sv
// rtl/plane_war_pkg.sv - shared state encoding and playfield constants for the plane war blocks
package plane_war_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int COORD_W = 10;

endpackage

// File: rtl/bullet_tick_gen.sv
// rtl/bullet_tick_gen.sv - free-running movement tick, one clk wide every TICK_DIV cycles
module bullet_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/player_bullet_ctrl.sv
// rtl/player_bullet_ctrl.sv - player bullet launch/move/retire controller feeding the collision judge
// Define PLAYER_BULLET_AUTOFIRE_EN to launch on a held fire level instead of only on a press edge.
module player_bullet_ctrl
  import plane_war_pkg::*;
#(
  parameter int TICK_DIV   = 250000,
  parameter int STEP       = 4,
  parameter int X_OFS      = 20,
  parameter int Y_OFS      = 10,
  parameter int COOL_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic [COORD_W-1:0] pp_x,
  input  logic [COORD_W-1:0] pp_y,
  input  logic               hit,
  output logic [COORD_W-1:0] b_x,
  output logic [COORD_W-1:0] b_y,
  output logic               mybullet_en,
  output logic [7:0]         shot_cnt
);

  localparam int CCW = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_OFS_C    = COORD_W'(X_OFS);
  localparam logic [COORD_W-1:0] Y_OFS_C    = COORD_W'(Y_OFS);
  localparam logic [COORD_W-1:0] LAUNCH_MIN = COORD_W'(Y_OFS + STEP);
  localparam logic [CCW-1:0]     COOL_LAST  = CCW'(COOL_TICKS - 1);

  state_t             state, state_n;
  logic [COORD_W-1:0] bx_n, by_n;
  logic [7:0]         shot_n;
  logic [CCW-1:0]     cool_cnt, cool_n;
  logic               fire_s1, fire_sync, fire_dly;
  logic               fire_edge, launch_req, tick;

  bullet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign fire_edge = fire_sync & ~fire_dly;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign launch_req = fire_sync;
`else
  assign launch_req = fire_edge;
`endif

  // The bullet exists exactly while flying, so the enable is decoded from state.
  assign mybullet_en = (state == FLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b_x       <= '0;
      b_y       <= '0;
      shot_cnt  <= '0;
      cool_cnt  <= '0;
      fire_s1   <= 1'b0;
      fire_sync <= 1'b0;
      fire_dly  <= 1'b0;
    end else begin
      state     <= state_n;
      b_x       <= bx_n;
      b_y       <= by_n;
      shot_cnt  <= shot_n;
      cool_cnt  <= cool_n;
      fire_s1   <= fire;
      fire_sync <= fire_s1;
      fire_dly  <= fire_sync;
    end
  end

  always_comb begin
    state_n = state;
    bx_n    = b_x;
    by_n    = b_y;
    shot_n  = shot_cnt;
    cool_n  = cool_cnt;
    unique case (state)
      IDLE: begin
        if (launch_req && (pp_y >= LAUNCH_MIN)) begin
          bx_n    = pp_x + X_OFS_C;
          by_n    = pp_y - Y_OFS_C;
          shot_n  = shot_cnt + 8'd1;
          state_n = FLY;
        end
      end
      FLY: begin
        // A hit wins over a coincident tick so the retired position is the one judged.
        if (hit) begin
          cool_n  = '0;
          state_n = COOL;
        end else if (tick) begin
          if (b_y < STEP_C) begin
            cool_n  = '0;
            state_n = COOL;
          end else begin
            by_n = b_y - STEP_C;
          end
        end
      end
      COOL: begin
        if (tick) begin
          if (cool_cnt == COOL_LAST) begin
            cool_n  = '0;
            state_n = IDLE;
          end else begin
            cool_n = cool_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// tb/tb_player_bullet_ctrl.sv - scoreboard bench for player_bullet_ctrl (TICK_DIV=4)
module tb_player_bullet_ctrl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       fire = 1'b0;
  logic       hit  = 1'b0;
  logic [9:0] pp_x = '0;
  logic [9:0] pp_y = '0;
  logic [9:0] b_x, b_y;
  logic       mybullet_en;
  logic [7:0] shot_cnt;

  int tests = 0;
  int fails = 0;
  int k = 0;

  logic [28:0] exp_q[$];
  logic [28:0] mon_cur, mon_exp, mon_prev;
  bit          mon_first = 1'b1;

  player_bullet_ctrl #(
    .TICK_DIV   (4),
    .STEP       (4),
    .X_OFS      (20),
    .Y_OFS      (10),
    .COOL_TICKS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fire        (fire),
    .pp_x        (pp_x),
    .pp_y        (pp_y),
    .hit         (hit),
    .b_x         (b_x),
    .b_y         (b_y),
    .mybullet_en (mybullet_en),
    .shot_cnt    (shot_cnt)
  );

  always #5 clk = ~clk;

  // Reference phase of the free-running tick: tick is high while k%4 == 3.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  function automatic logic [28:0] snap(input int x, input int y, input int en, input int c);
    logic [28:0] s;
    s = {x[9:0], y[9:0], en[0], c[7:0]};
    return s;
  endfunction

  function automatic string fmt(input logic [28:0] s);
    return $sformatf("x=%0d y=%0d en=%0d cnt=%0d", s[28:19], s[18:9], s[8], s[7:0]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every change of the output bundle must match the next queued snapshot.
  always @(negedge clk) begin
    mon_cur = {b_x, b_y, mybullet_en, shot_cnt};
    if (mon_first || (mon_cur !== mon_prev)) begin
      mon_first = 1'b0;
      mon_prev  = mon_cur;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %s expected no change", fmt(mon_cur));
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_cur !== mon_exp) begin
          fails++;
          $display("FAIL output_seq: got %s expected %s", fmt(mon_cur), fmt(mon_exp));
        end
      end
    end
  end

  task automatic press();
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_edge();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (k % 4 == 3) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL tick_wait: got no tick expected one within 8 cycles");
    end
  endtask

  task automatic hit_on_tick();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (k % 4 == 3) begin
        hit  = 1'b1;
        done = 1'b1;
      end
    end
    @(negedge clk);
    hit = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL hit_align: got no tick cycle expected one within 8 cycles");
    end
  endtask

  task automatic push_flight(input int x, input int y0, input int c);
    for (int y = y0; y >= 0; y -= 4) exp_q.push_back(snap(x, y, 1, c));
    exp_q.push_back(snap(x, y0 % 4, 0, c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_q.push_back(snap(0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Launch with latency check, two ticks of travel, then a hit on a tick cycle.
    pp_x = 10'd300;
    pp_y = 10'd440;
    exp_q.push_back(snap(320, 430, 1, 1));
    exp_q.push_back(snap(320, 426, 1, 1));
    exp_q.push_back(snap(320, 422, 1, 1));
    exp_q.push_back(snap(320, 422, 0, 1));
    @(negedge clk);
    fire = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fire = 1'b0;
    @(posedge clk);
    #1 check("latency_edge2_en", int'(mybullet_en), 0);
    @(posedge clk);
    #1 check("latency_edge3_en", int'(mybullet_en), 1);
    check("launch_b_x", int'(b_x), 320);
    tick_edge();
    tick_edge();
    hit_on_tick();

    // Press two ticks into cooldown is dropped.
    tick_edge();
    tick_edge();
    press();
    repeat (3) @(posedge clk);
    #1 check("cool_press_shot_cnt", int'(shot_cnt), 1);

    // After cooldown, launch low and run off the top edge; a mid-flight press is dropped.
    repeat (18) tick_edge();
    pp_x = 10'd100;
    pp_y = 10'd30;
    push_flight(120, 20, 2);
    press();
    press();
    repeat (30) tick_edge();
    check("after_exit_en", int'(mybullet_en), 0);

    // Launch guard below Y_OFS+STEP, and hit ignored while idle.
    pp_y = 10'd10;
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    press();
    repeat (4) @(posedge clk);
    #1 check("guard_10_shot_cnt", int'(shot_cnt), 2);
    pp_y = 10'd13;
    press();
    repeat (4) @(posedge clk);
    #1 check("guard_13_shot_cnt", int'(shot_cnt), 2);

    // Exactly at the guard, with b_x truncation (1010+20 -> 6).
    pp_x = 10'd1010;
    pp_y = 10'd14;
    push_flight(6, 4, 3);
    press();
    repeat (22) tick_edge();

    // Reset mid-flight, then relaunch and hit off-tick.
    pp_x = 10'd200;
    pp_y = 10'd300;
    exp_q.push_back(snap(220, 290, 1, 4));
    exp_q.push_back(snap(0, 0, 0, 0));
    press();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(snap(220, 290, 1, 1));
    exp_q.push_back(snap(220, 290, 0, 1));
    press();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    repeat (20) tick_edge();
    check("post_reset_shot_cnt", int'(shot_cnt), 1);

    // Held fire button.
    pp_x = 10'd0;
    pp_y = 10'd30;
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    push_flight(20, 20, 2);
    push_flight(20, 20, 3);
    push_flight(20, 20, 4);
    @(negedge clk);
    fire = 1'b1;
    for (int i = 0; i < 200 && !(shot_cnt == 8'd4 && !mybullet_en); i++) tick_edge();
    @(negedge clk);
    fire = 1'b0;
    repeat (20) tick_edge();
    check("autofire_shot_cnt", int'(shot_cnt), 4);
`else
    push_flight(20, 20, 2);
    @(negedge clk);
    fire = 1'b1;
    repeat (100) tick_edge();
    @(negedge clk);
    fire = 1'b0;
    repeat (5) tick_edge();
    check("hold_single_shot_cnt", int'(shot_cnt), 2);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
